// File: rtl/serial_right_shifter.sv
`timescale 1ns/1ps
// Purpose : SRL/SRA by a variable amount, one bit position per clock, under a start/done handshake.
// Latency : start at E0 -> busy for shamt+1 cycles -> done for one cycle -> IDLE after E(shamt+2).
// Backpressure: none; start is only sampled in IDLE, requests in SHIFT/DONE are dropped (no queueing).
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   start                 request, sampled only in IDLE
//   arith                 1 = sign fill (SRA), 0 = zero fill (SRL); captured with start
//   data_in, shamt        operand and shift amount (0..WIDTH-1); captured with start
//   busy                  high while shifting
//   done                  one-cycle pulse, result valid
//   result                shift register contents; stable from done until the next accepted start
module serial_right_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5     // must equal log2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             arith,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [SHW-1:0]   cnt;
  logic             arith_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      arith_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sr      <= data_in;
            cnt     <= shamt;
            arith_q <= arith;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // The cnt==0 cycle is spent without shifting, so shamt=0 still
          // takes one SHIFT cycle and every operation has the same shape.
          if (cnt != '0) begin
            sr  <= {arith_q & sr[WIDTH-1], sr[WIDTH-1:1]};
            cnt <= cnt - SHW'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Decoded straight from the state register: glitch-free and mutually exclusive.
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign result = sr;

endmodule

// File: tb/tb_serial_right_shifter.sv
`timescale 1ns/1ps
module tb_serial_right_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        arith;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_done_cyc = 0;
  int this_done_cyc = 0;

  serial_right_shifter #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .arith   (arith),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain Verilog shift operators.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic a);
    if (a) return 32'($signed(d) >>> s);
    else   return d >> s;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at the negedge of the
  // first IDLE cycle afterwards, so consecutive calls are back-to-back.
  task automatic do_op(input logic [31:0] d, input int s, input logic a,
                       input bit inject, input string tag);
    int          busy_cnt;
    int          n;
    logic [31:0] exp;
    exp = ref_shift(d, s, a);
    start = 1'b1; data_in = d; shamt = 5'(s); arith = a;
    @(negedge clk);
    start = 1'b0; data_in = $urandom; shamt = 5'($urandom); arith = 1'($urandom);
    busy_cnt = 0;
    n = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      // A start raised here is sampled on an edge while still in SHIFT.
      start = (inject && n == 2);
      data_in = $urandom; shamt = 5'($urandom);
      n++;
      @(negedge clk);
    end
    check({tag, " done_seen"}, 32'(done), 32'd1);
    check({tag, " busy_cycles"}, busy_cnt, s + 1);
    check({tag, " result"}, result, exp);
    this_done_cyc = cyc;
    // Start raised in the DONE cycle is sampled on the DONE->IDLE edge and must be dropped.
    start = inject;
    data_in = 32'h1234_5678; shamt = 5'd3; arith = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check({tag, " done_pulse_width"}, 32'(done), 32'd0);
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " result_hold"}, result, exp);
  endtask

  initial begin
    int done_seen;
    int s;
    logic [31:0] d;

    rst_n = 1'b0; start = 1'b0; arith = 1'b0; data_in = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst_n = 1'b1;

    // Directed cases; the first start is presented straight after release.
    do_op(32'h8000_0000, 4,  1'b0, 1'b0, "srl4");
    do_op(32'h8000_0000, 4,  1'b1, 1'b0, "sra4");
    do_op(32'h8000_0000, 31, 1'b1, 1'b0, "sra31_neg");
    do_op(32'h7FFF_FFFF, 31, 1'b1, 1'b0, "sra31_pos");
    do_op(32'hDEAD_BEEF, 0,  1'b0, 1'b0, "shamt0");
    do_op(32'h0000_1000, 2,  1'b0, 1'b0, "byte2word");
    do_op(32'h0000_FF00, 8,  1'b0, 1'b1, "ignored_start");
    do_op(32'hA5A5_0000, 5,  1'b1, 1'b0, "after_ignored");

    // Reset three cycles into a 20-bit shift.
    start = 1'b1; data_in = 32'hFFFF_0000; shamt = 5'd20; arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst busy", 32'(busy), 32'd0);
    check("async_rst done", 32'(done), 32'd0);
    check("async_rst result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("abort no_activity", done_seen, 0);
    do_op(32'hC000_0001, 20, 1'b1, 1'b0, "post_reset");

    // Back-to-back randomized. start is only sampled in IDLE, so the earliest
    // re-accept is the edge after the DONE->IDLE edge: done-to-done = shamt+3.
    last_done_cyc = this_done_cyc;
    for (int i = 0; i < 50; i++) begin
      d = $urandom;
      s = $urandom_range(0, 31);
      do_op(d, s, 1'(i), 1'b0, $sformatf("rand%0d", i));
      check($sformatf("rand%0d spacing", i), this_done_cyc - last_done_cyc, s + 3);
      last_done_cyc = this_done_cyc;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
